// File: rtl/ifu_lockstep_ctrl_if.sv
// Handshake/status bundle between the lockstep sequencer and the IFU buffer
// chain, main core and shadow core.
interface ifu_lockstep_ctrl_if #(
  parameter int unsigned SIG_W  = 32,
  parameter int unsigned ERRC_W = 8
);
  logic              ls_en;
  logic              hold_req;
  logic              main_valid;
  logic [SIG_W-1:0]  main_sig;
  logic              shdw_valid;
  logic [SIG_W-1:0]  shdw_sig;
  logic              err_clr;
  logic              buf_lden;
  logic              shdw_run;
  logic              ls_mismatch;
  logic              ls_err;
  logic [ERRC_W-1:0] err_cnt;
  logic [1:0]        ls_state;

  modport master (
    output ls_en, hold_req, main_valid, main_sig, shdw_valid, shdw_sig, err_clr,
    input  buf_lden, shdw_run, ls_mismatch, ls_err, err_cnt, ls_state
  );

  modport slave (
    input  ls_en, hold_req, main_valid, main_sig, shdw_valid, shdw_sig, err_clr,
    output buf_lden, shdw_run, ls_mismatch, ls_err, err_cnt, ls_state
  );
endinterface

// File: rtl/ifu_lockstep_ctrl.sv
// Lockstep sequencer: fills the DELAY-stage IFU buffer, runs the shadow core
// DELAY loads behind the main core and compares fetch signatures.
module ifu_lockstep_ctrl #(
  parameter int unsigned DELAY  = 2,
  parameter int unsigned SIG_W  = 32,
  parameter int unsigned ERRC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  ifu_lockstep_ctrl_if.slave bus
);

  if (DELAY < 1 || DELAY > 4) begin : g_delay_range
    $error("ifu_lockstep_ctrl: DELAY must be within 1..4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] FILL_LAST = 2'(DELAY - 1);

  state_t           state;
  logic [1:0]       fill_cnt;
  logic [DELAY-1:0] pipe_v;
  logic [SIG_W-1:0] pipe_s [DELAY];
  logic             pv_o;
  logic [SIG_W-1:0] ps_o;
  logic             cmp_en;
  logic             mm;

  // Load enable in FILL follows hold_req combinationally so a stalled fill
  // cycle neither advances the buffer nor the fill count.
  always_comb begin
    bus.buf_lden = 1'b0;
    bus.shdw_run = 1'b0;
    cmp_en       = 1'b0;
    unique case (state)
      FILL: bus.buf_lden = !bus.hold_req;
      RUN: begin
        bus.buf_lden = 1'b1;
        bus.shdw_run = 1'b1;
        cmp_en       = !bus.hold_req;
      end
      default: ;
    endcase
  end

  assign bus.ls_state = state;
  assign pv_o         = pipe_v[DELAY-1];
  assign ps_o         = pipe_s[DELAY-1];
  assign mm = cmp_en & ((pv_o != bus.shdw_valid) |
                        (pv_o & bus.shdw_valid & (ps_o != bus.shdw_sig)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fill_cnt        <= '0;
      pipe_v          <= '0;
      for (int unsigned i = 0; i < DELAY; i++) pipe_s[i] <= '0;
      bus.ls_mismatch <= 1'b0;
      bus.ls_err      <= 1'b0;
      bus.err_cnt     <= '0;
    end else begin
      bus.ls_mismatch <= mm;
      // Clear takes effect first so a coincident mismatch still counts once.
      if (bus.err_clr) begin
        bus.ls_err  <= mm;
        bus.err_cnt <= ERRC_W'(mm);
      end else if (mm) begin
        bus.ls_err <= 1'b1;
        if (bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + 1'b1;
      end

      if (!bus.ls_en) begin
        state    <= IDLE;
        fill_cnt <= '0;
        pipe_v   <= '0;
      end else begin
        if (bus.buf_lden) begin
          pipe_v[0] <= bus.main_valid;
          pipe_s[0] <= bus.main_sig;
          for (int unsigned i = 1; i < DELAY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_s[i] <= pipe_s[i-1];
          end
        end
        unique case (state)
          IDLE: state <= FILL;
          FILL: begin
            if (bus.buf_lden) begin
              if (fill_cnt == FILL_LAST) begin
                state    <= RUN;
                fill_cnt <= '0;
              end else begin
                fill_cnt <= fill_cnt + 2'd1;
              end
            end
          end
          RUN:  if (bus.hold_req)  state <= HOLD;
          HOLD: if (!bus.hold_req) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_lockstep_ctrl.sv
// Bench for ifu_lockstep_ctrl: load-counting reference model with per-cycle
// checks plus directed scenarios with literal expectations.
module tb_ifu_lockstep_ctrl;
  localparam int unsigned DELAY  = 2;
  localparam int unsigned SIG_W  = 32;
  localparam int unsigned ERRC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_lockstep_ctrl_if #(.SIG_W(SIG_W), .ERRC_W(ERRC_W)) bus ();

  ifu_lockstep_ctrl #(.DELAY(DELAY), .SIG_W(SIG_W), .ERRC_W(ERRC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: enabled flag, loads taken since fill start, hold flag,
  // and a queue holding the last DELAY loaded samples (newest at index 0).
  bit                m_en   = 1'b0;
  bit                m_held = 1'b0;
  int unsigned       m_nl   = 0;
  logic [SIG_W:0]    m_q[$];
  logic              e_mm   = 1'b0;
  logic              e_err  = 1'b0;
  logic [ERRC_W-1:0] e_cnt  = '0;
  int unsigned       mi     = 0;
  int unsigned       sj     = 0;
  bit                flip_req = 1'b0;
  bit                force_mm = 1'b0;

  function automatic int m_state();
    if (!m_en) return 0;
    if (m_nl < DELAY) return 1;
    if (m_held) return 3;
    return 2;
  endfunction

  function automatic bit m_lden();
    int s;
    s = m_state();
    if (s == 1) return !bus.hold_req;
    return s == 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    int             st;
    bit             ld;
    bit             mm;
    logic [SIG_W:0] po;
    if (rst) begin
      m_en = 1'b0; m_held = 1'b0; m_nl = 0;
      m_q.delete();
      repeat (DELAY) m_q.push_back('0);
      e_mm = 1'b0; e_err = 1'b0; e_cnt = '0;
      mi = 0; sj = 0;
    end else begin
      st = m_state();
      ld = m_lden();
      po = m_q[DELAY-1];
      mm = (st == 2) && !bus.hold_req &&
           ((po[SIG_W] != bus.shdw_valid) ||
            (po[SIG_W] && bus.shdw_valid && (po[SIG_W-1:0] != bus.shdw_sig)));
      if (bus.err_clr) begin e_err = 1'b0; e_cnt = '0; end
      if (mm) begin
        e_err = 1'b1;
        if (e_cnt != '1) e_cnt = e_cnt + 1'b1;
      end
      e_mm = mm;
      if (!bus.ls_en) begin
        m_en = 1'b0; m_held = 1'b0; m_nl = 0;
        m_q.delete();
        repeat (DELAY) m_q.push_back('0);
        mi = 0; sj = 0;
      end else begin
        if (ld) begin
          m_q.push_front({bus.main_valid, bus.main_sig});
          void'(m_q.pop_back());
          mi++;
        end
        if (st == 2) sj++;
        case (st)
          0: m_en = 1'b1;
          1: if (ld) m_nl++;
          default: m_held = bus.hold_req;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Main stream advances per buffer load, shadow stream per shdw_run cycle;
  // every 7th sample is invalid with deliberately different signatures.
  task automatic drive_data();
    bit v;
    v = (mi % 7) != 3;
    bus.main_valid = v;
    bus.main_sig   = v ? SIG_W'(32'h1000 + mi) : SIG_W'(32'hDEAD_0000 + mi);
    v = (sj % 7) != 3;
    bus.shdw_valid = v ^ force_mm;
    bus.shdw_sig   = v ? SIG_W'(32'h1000 + sj) : SIG_W'(32'hBEEF_0000);
    if (flip_req && v && m_state() == 2 && !bus.hold_req) begin
      bus.shdw_sig[5] = ~bus.shdw_sig[5];
      flip_req = 1'b0;
    end
  endtask

  task automatic cmp_all();
    chk("ls_state",    int'(bus.ls_state),    m_state());
    chk("buf_lden",    int'(bus.buf_lden),    int'(m_lden()));
    chk("shdw_run",    int'(bus.shdw_run),    int'(m_state() == 2));
    chk("ls_mismatch", int'(bus.ls_mismatch), int'(e_mm));
    chk("ls_err",      int'(bus.ls_err),      int'(e_err));
    chk("err_cnt",     int'(bus.err_cnt),     int'(e_cnt));
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
    drive_data();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ls_en = 1'b0; bus.hold_req = 1'b0; bus.err_clr = 1'b0;
    drive_data();
    cyc(); cyc();
    chk("rst_state", int'(bus.ls_state), 0);
    chk("rst_lden",  int'(bus.buf_lden), 0);
    chk("rst_cnt",   int'(bus.err_cnt),  0);
    rst = 1'b0;

    // Enable at cycle 0: loads from cycle 1, RUN at cycle 3.
    bus.ls_en = 1'b1;
    cyc();
    chk("c1_state", int'(bus.ls_state), 1);
    chk("c1_lden",  int'(bus.buf_lden), 1);
    cyc();
    chk("c2_state", int'(bus.ls_state), 1);
    chk("c2_run",   int'(bus.shdw_run), 0);
    cyc();
    chk("c3_state",  int'(bus.ls_state), 2);
    chk("c3_run",    int'(bus.shdw_run), 1);
    chk("model_c3",  m_state(), 2);

    // Matching streams.
    repeat (100) cyc();
    chk("match_cnt", int'(bus.err_cnt), 0);
    chk("match_err", int'(bus.ls_err),  0);

    // Single flipped bit on a valid compare cycle.
    flip_req = 1'b1;
    for (int k = 0; k < 10 && flip_req; k++) cyc();
    chk("flip_done", int'(flip_req), 0);
    cyc();
    chk("flip_pulse", int'(bus.ls_mismatch), 1);
    cyc();
    chk("flip_pulse_end", int'(bus.ls_mismatch), 0);
    chk("flip_err", int'(bus.ls_err),  1);
    chk("flip_cnt", int'(bus.err_cnt), 1);

    // Hold during RUN: three frozen cycles, clean resume.
    bus.hold_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_lden", int'(bus.buf_lden), 0);
      chk("hold_run",  int'(bus.shdw_run), 0);
    end
    bus.hold_req = 1'b0;
    repeat (20) cyc();
    chk("hold_resume_cnt", int'(bus.err_cnt), 1);

    // Drop enable in RUN; errors survive.
    bus.ls_en = 1'b0;
    cyc();
    chk("drop_state", int'(bus.ls_state), 0);
    chk("drop_lden",  int'(bus.buf_lden), 0);
    chk("drop_run",   int'(bus.shdw_run), 0);
    chk("drop_err",   int'(bus.ls_err),   1);

    // Refill with hold_req during FILL: RUN entry moves from cycle 3 to 6.
    bus.ls_en = 1'b1;
    cyc();
    bus.hold_req = 1'b1;
    cyc(); cyc(); cyc();
    bus.hold_req = 1'b0;
    cyc();
    chk("fillhold_c5", int'(bus.ls_state), 1);
    cyc();
    chk("fillhold_c6", int'(bus.ls_state), 2);
    chk("model_c6",    m_state(), 2);
    repeat (30) cyc();
    chk("refill_cnt", int'(bus.err_cnt), 1);

    // Saturation, then clear coinciding with a mismatch.
    force_mm = 1'b1;
    drive_data();
    repeat (300) cyc();
    chk("sat_cnt", int'(bus.err_cnt), 8'hFF);
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    force_mm = 1'b0;
    drive_data();
    chk("clr_mm_cnt", int'(bus.err_cnt), 1);
    chk("clr_mm_err", int'(bus.ls_err),  1);
    repeat (5) cyc();
    chk("clr_after_cnt", int'(bus.err_cnt), 1);

    // Asynchronous reset in the middle of FILL.
    bus.ls_en = 1'b0;
    cyc();
    bus.ls_en = 1'b1;
    cyc(); cyc();
    chk("pre_rst_state", int'(bus.ls_state), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(bus.ls_state), 0);
    chk("arst_lden",  int'(bus.buf_lden), 0);
    chk("arst_err",   int'(bus.ls_err),   0);
    chk("arst_cnt",   int'(bus.err_cnt),  0);
    bus.ls_en = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    bus.ls_en = 1'b1;
    repeat (25) cyc();
    chk("post_rst_state", int'(bus.ls_state), 2);
    chk("post_rst_cnt",   int'(bus.err_cnt),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
